// File: rtl/pdm_pkg.sv
// Shared types and constants for the stereo PDM capture controller.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAKEUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } pdm_state_t;

  localparam int INPUT_FREQ       = 125_000_000;
  localparam int MIN_HALF         = 4;
  localparam int DEF_DIV_W        = 8;
  localparam int DEF_WORD_W       = 32;
  localparam int DEF_WAKEUP_EDGES = 4096;

  // Fastest M_CLK the divider can produce from the system clock.
  localparam int MCLK_MAX_HZ = INPUT_FREQ / (2 * MIN_HALF);

  function automatic int clamp_half(input int half);
    return (half < MIN_HALF) ? MIN_HALF : half;
  endfunction

endpackage

// File: rtl/pdm_clk_div_prog.sv
// Programmable half-period M_CLK divider; half-period is latched on load and
// a stop request suppresses any rising toggle so M_CLK parks low cleanly.
module pdm_clk_div_prog
  import pdm_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic             stop_low,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             m_clk,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] cnt_q;
  logic             at_end;
  logic             toggle;

  assign at_end   = (cnt_q == (half_q - DIV_W'(1)));
  assign toggle   = active && at_end && !(stop_low && !m_clk);
  assign rise_stb = toggle && !m_clk;
  assign fall_stb = toggle && m_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= DIV_W'(MIN_HALF);
      cnt_q  <= '0;
      m_clk  <= 1'b0;
    end else begin
      if (load) begin
        half_q <= DIV_W'(clamp_half(int'(div_cfg)));
      end
      if (!active) begin
        cnt_q <= '0;
        m_clk <= 1'b0;
      end else if (at_end) begin
        cnt_q <= '0;
        m_clk <= m_clk ^ toggle;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Stereo PDM capture controller: start-up sequencing, M_CLK generation,
// two-channel deserialisation and a single-entry valid/ready output stage.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int DIV_W        = DEF_DIV_W,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int WAKEUP_EDGES = DEF_WAKEUP_EDGES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DIV_W-1:0]    div_cfg,
  input  logic                pdm_data,
  output logic                M_CLK,
  output logic [2*WORD_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                running,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int WK_W = $clog2(WAKEUP_EDGES + 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
  localparam logic [WK_W-1:0] WAKE_LAST = WK_W'(WAKEUP_EDGES - 1);

  pdm_state_t        state_q;
  pdm_state_t        state_d;
  logic              pdm_meta;
  logic              pdm_sync;
  logic              rise_stb;
  logic              fall_stb;
  logic [WK_W-1:0]   wake_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [WORD_W-1:0] ch0_q;
  logic [WORD_W-1:0] ch1_q;
  logic [WORD_W-1:0] ch1_next;
  logic              in_run;
  logic              pair_done;
  logic              out_busy;

  pdm_clk_div_prog #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_q == ST_IDLE) && enable),
    .active   (state_q != ST_IDLE),
    .stop_low (state_q == ST_STOP),
    .div_cfg  (div_cfg),
    .m_clk    (M_CLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdm_meta <= 1'b0;
      pdm_sync <= 1'b0;
    end else begin
      pdm_meta <= pdm_data;
      pdm_sync <= pdm_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // STOP leaves on the falling toggle if M_CLK is high, else immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_WAKEUP;
      ST_WAKEUP: begin
        if (!enable) begin
          state_d = ST_STOP;
        end else if (fall_stb && (wake_cnt == WAKE_LAST)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:    if (!enable) state_d = ST_STOP;
      ST_STOP:   if (!M_CLK || fall_stb) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt <= '0;
    end else if (state_q != ST_WAKEUP) begin
      wake_cnt <= '0;
    end else if (fall_stb) begin
      wake_cnt <= wake_cnt + WK_W'(1);
    end
  end

  assign running   = (state_q == ST_RUN);
  assign in_run    = (state_q == ST_RUN);
  assign ch1_next  = {ch1_q[WORD_W-2:0], pdm_sync};
  assign pair_done = in_run && fall_stb && (bit_cnt == BIT_LAST);
  assign out_busy  = m_tvalid && !m_tready;

  // Rising toggles carry ch0 bits, falling toggles carry ch1 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch0_q   <= '0;
      ch1_q   <= '0;
      bit_cnt <= '0;
    end else if (!in_run) begin
      ch0_q   <= '0;
      ch1_q   <= '0;
      bit_cnt <= '0;
    end else begin
      if (rise_stb) begin
        ch0_q <= {ch0_q[WORD_W-2:0], pdm_sync};
      end
      if (fall_stb) begin
        ch1_q   <= ch1_next;
        bit_cnt <= pair_done ? '0 : bit_cnt + BC_W'(1);
      end
    end
  end

  // Stream: a word moves when m_tvalid && m_tready; while m_tvalid is high and
  // m_tready low, m_tdata is frozen and any newly completed pair is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pair_done && !out_busy) begin
        m_tdata  <= {ch1_next, ch0_q};
        m_tvalid <= 1'b1;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (pair_done && out_busy) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
